// File: rtl/intdisp_pkg.sv
// Shared types and vector arithmetic for the interrupt dispatcher.
package intdisp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    REDIRECT,
    ISR,
    RETURN
  } state_e;

  localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0100;
  localparam int unsigned DEF_VEC_STRIDE = 16;

  // Wide intermediate; caller truncates to XLEN to get modulo-2^XLEN wrap.
  function automatic logic [63:0] vec_addr(input logic [63:0] base,
                                           input logic [63:0] stride,
                                           input logic [63:0] idx);
    return base + idx * stride;
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-first priority encoder; idx is 0 when nothing is requested.
module prio_enc #(
  parameter int unsigned NSRC = 4,
  localparam int unsigned IDXW = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic [NSRC-1:0] req_i,
  output logic [IDXW-1:0] idx_c_o,
  output logic            valid_c_o
);

  always_comb begin
    idx_c_o   = '0;
    valid_c_o = 1'b0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_c_o   = IDXW'(i);
        valid_c_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_dispatch.sv
// Interrupt entry/exit sequencer: latch sources, flush, vector, return on mret.
// Optional per-source enable mask when INTDISP_MASK_EN is defined.
module interrupt_dispatch
  import intdisp_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     NSRC       = 4,
  parameter logic [XLEN-1:0] VEC_BASE   = XLEN'(DEF_VEC_BASE),
  parameter int unsigned     VEC_STRIDE = DEF_VEC_STRIDE,
  localparam int unsigned    IDXW       = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic            CLK_I,
  input  logic            RST_N_I,
  input  logic            inti,
  input  logic [NSRC-1:0] irq_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            flush_ack_i,
  input  logic            mret_i,
`ifdef INTDISP_MASK_EN
  input  logic            mask_we_i,
  input  logic [NSRC-1:0] mask_wdata_i,
`endif
  output logic            flush_req_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic [XLEN-1:0] epc_o,
  output logic [IDXW-1:0] cause_o,
  output logic            in_isr_o
);

  state_e          state_q, state_d;
  logic [NSRC-1:0] pend_q, pend_d, elig, clr;
  logic [XLEN-1:0] epc_q, epc_d, rpc_q, rpc_d;
  logic [IDXW-1:0] cause_q, cause_d, sel_idx;
  logic            sel_valid, redir_d, redir_q, flush_q, isr_q;

`ifdef INTDISP_MASK_EN
  logic [NSRC-1:0] mask_q;

  always_ff @(posedge CLK_I) begin
    if (!RST_N_I)       mask_q <= '1;
    else if (mask_we_i) mask_q <= mask_wdata_i;
  end

  assign elig = pend_q & mask_q;
`else
  assign elig = pend_q;
`endif

  prio_enc #(.NSRC(NSRC)) u_prio (
    .req_i     (elig),
    .idx_c_o   (sel_idx),
    .valid_c_o (sel_valid)
  );

  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    rpc_d   = rpc_q;
    redir_d = 1'b0;
    clr     = '0;
    case (state_q)
      IDLE:     if (sel_valid) state_d = FLUSH;
      FLUSH: begin
        // Source chosen at ack time, so a later higher-priority arrival wins.
        if (!sel_valid) begin
          state_d = IDLE;
        end else if (flush_ack_i) begin
          state_d = REDIRECT;
          epc_d   = pc_i;
          cause_d = sel_idx;
          clr     = NSRC'(1) << sel_idx;
          redir_d = 1'b1;
          rpc_d   = XLEN'(vec_addr(64'(VEC_BASE), 64'(VEC_STRIDE), 64'(sel_idx)));
        end
      end
      REDIRECT: state_d = ISR;
      ISR: begin
        if (mret_i) begin
          state_d = RETURN;
          redir_d = 1'b1;
          rpc_d   = epc_q;
        end
      end
      RETURN:   state_d = sel_valid ? FLUSH : IDLE;
      default:  state_d = IDLE;
    endcase
    // New requests win over the clear of the bit being dispatched.
    pend_d = (pend_q & ~clr) | (inti ? irq_i : '0);
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_N_I) begin
      state_q <= IDLE;
      pend_q  <= '0;
      epc_q   <= '0;
      cause_q <= '0;
      rpc_q   <= '0;
      redir_q <= 1'b0;
      flush_q <= 1'b0;
      isr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      rpc_q   <= rpc_d;
      redir_q <= redir_d;
      flush_q <= (state_d == FLUSH);
      isr_q   <= (state_d == ISR);
    end
  end

  assign flush_req_o   = flush_q;
  assign redirect_o    = redir_q;
  assign redirect_pc_o = rpc_q;
  assign epc_o         = epc_q;
  assign cause_o       = cause_q;
  assign in_isr_o      = isr_q;

endmodule

// File: tb/tb_interrupt_dispatch.sv
// Scoreboard bench for interrupt_dispatch: directed scenarios plus random traffic.
module tb_interrupt_dispatch;

  localparam logic [31:0] VBASE = 32'h0000_0100;
  localparam int unsigned VSTR  = 16;

  logic        clk = 1'b0;
  logic        rst_n, inti, ack, mret;
  logic [3:0]  irq;
  logic [31:0] pc;
  logic        flush_req, redirect, in_isr;
  logic [31:0] redirect_pc, epc;
  logic [1:0]  cause;
`ifdef INTDISP_MASK_EN
  logic        mask_we;
  logic [3:0]  mask_wdata;
`endif

  always #5 clk = ~clk;

  interrupt_dispatch #(.XLEN(32), .NSRC(4), .VEC_BASE(VBASE), .VEC_STRIDE(VSTR)) dut (
    .CLK_I         (clk),
    .RST_N_I       (rst_n),
    .inti          (inti),
    .irq_i         (irq),
    .pc_i          (pc),
    .flush_ack_i   (ack),
    .mret_i        (mret),
`ifdef INTDISP_MASK_EN
    .mask_we_i     (mask_we),
    .mask_wdata_i  (mask_wdata),
`endif
    .flush_req_o   (flush_req),
    .redirect_o    (redirect),
    .redirect_pc_o (redirect_pc),
    .epc_o         (epc),
    .cause_o       (cause),
    .in_isr_o      (in_isr)
  );

  typedef struct {
    logic [31:0] tgt;
    logic        entry;
    logic [1:0]  cause;
    logic [31:0] epc;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state: phase 0..4 = idle, flushing, redirecting, in handler, returning.
  int          m_phase;
  logic [3:0]  m_pend, m_mask;
  logic [31:0] m_epc, m_rpc;
  logic [1:0]  m_cause;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (redirect === 1'b1) begin
      chk("sb_has_entry", 64'(sbq.size() > 0), 1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("redirect_pc", 64'(redirect_pc), 64'(e.tgt));
        if (e.entry) begin
          chk("entry_cause", 64'(cause), 64'(e.cause));
          chk("entry_epc", 64'(epc), 64'(e.epc));
        end
      end
    end
  end

  task automatic step();
    int         idx;
    logic [3:0] eff, clrb;
    if (!rst_n) begin
      m_phase = 0; m_pend = '0; m_epc = '0; m_cause = '0; m_rpc = '0; m_mask = '1;
    end else begin
      eff  = m_pend & m_mask;
      clrb = '0;
      case (m_phase)
        0: if (eff != 0) m_phase = 1;
        1: begin
          if (eff == 0) m_phase = 0;
          else if (ack) begin
            idx     = lowest(eff);
            m_epc   = pc;
            m_cause = 2'(idx);
            clrb    = 4'(1 << idx);
            m_rpc   = VBASE + 32'(idx) * VSTR;
            sbq.push_back('{tgt: m_rpc, entry: 1'b1, cause: m_cause, epc: m_epc});
            m_phase = 2;
          end
        end
        2: m_phase = 3;
        3: if (mret) begin
          m_rpc = m_epc;
          sbq.push_back('{tgt: m_epc, entry: 1'b0, cause: 2'd0, epc: 32'd0});
          m_phase = 4;
        end
        4: m_phase = (eff != 0) ? 1 : 0;
        default: m_phase = 0;
      endcase
      m_pend = (m_pend & ~clrb) | (inti ? irq : 4'b0);
`ifdef INTDISP_MASK_EN
      if (mask_we) m_mask = mask_wdata;
`endif
    end
    @(posedge clk);
    #1;
    chk("flush_req", 64'(flush_req), 64'(m_phase == 1));
    chk("in_isr", 64'(in_isr), 64'(m_phase == 3));
    chk("redirect", 64'(redirect), 64'(m_phase == 2 || m_phase == 4));
    chk("redirect_pc_hold", 64'(redirect_pc), 64'(m_rpc));
    chk("epc", 64'(epc), 64'(m_epc));
    chk("cause", 64'(cause), 64'(m_cause));
  endtask

  task automatic cyc(input logic r, input logic i, input logic [3:0] q, input logic a, input logic m);
    rst_n = r; inti = i; irq = q; ack = a; mret = m;
    step();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1, 0, 4'b0, 0, 0);
  endtask

  initial begin
    pc = 32'h0000_2000;
`ifdef INTDISP_MASK_EN
    mask_we = 1'b0; mask_wdata = 4'b0;
`endif
    cyc(0, 0, 4'b0, 0, 0);
    cyc(0, 0, 4'b0, 0, 0);
    idle(2);

    // Reset while flushing
    cyc(1, 1, 4'b0001, 0, 0);
    idle(2);
    chk("mid_flush_req", 64'(flush_req), 1);
    cyc(0, 0, 4'b0, 0, 0);
    chk("rst_flush_req", 64'(flush_req), 0);
    chk("rst_epc", 64'(epc), 0);
    idle(3);

    // Single source 2, ack three cycles into the flush
    cyc(1, 1, 4'b0100, 0, 0);
    idle(2);
    idle(2);
    cyc(1, 0, 4'b0, 1, 0);
    chk("s2_redirect", 64'(redirect), 1);
    chk("s2_vector", 64'(redirect_pc), 64'h120);
    chk("s2_cause", 64'(cause), 2);
    chk("s2_epc", 64'(epc), 64'h2000);
    idle(1);
    chk("s2_in_isr", 64'(in_isr), 1);
    idle(2);
    cyc(1, 0, 4'b0, 0, 1);
    chk("s2_ret_pc", 64'(redirect_pc), 64'h2000);
    idle(3);

    // Higher-priority arrival during FLUSH overtakes source 3
    cyc(1, 1, 4'b1000, 0, 0);
    idle(2);
    cyc(1, 1, 4'b0001, 0, 0);
    idle(1);
    cyc(1, 0, 4'b0, 1, 0);
    chk("pri_vector", 64'(redirect_pc), 64'h100);
    chk("pri_cause", 64'(cause), 0);
    idle(2);
    cyc(1, 0, 4'b0, 0, 1);
    chk("pri_ret_pc", 64'(redirect_pc), 64'h2000);
    idle(1);
    chk("b2b_flush", 64'(flush_req), 1);
    pc = 32'h0000_3000;
    cyc(1, 0, 4'b0, 1, 0);
    chk("s3_vector", 64'(redirect_pc), 64'h130);
    idle(1);

    // No nesting: source 1 waits for mret
    cyc(1, 1, 4'b0010, 0, 0);
    idle(3);
    chk("nest_blocked", 64'(flush_req), 0);
    cyc(1, 0, 4'b0, 0, 1);
    chk("nest_ret_pc", 64'(redirect_pc), 64'h3000);
    idle(1);
    chk("nest_flush_next", 64'(flush_req), 1);
    cyc(1, 0, 4'b0, 1, 0);
    chk("s1_vector", 64'(redirect_pc), 64'h110);
    idle(2);
    cyc(1, 0, 4'b0, 0, 1);
    idle(3);

    // Spurious strobes
    cyc(1, 0, 4'b0, 0, 1);
    chk("spur_mret_redir", 64'(redirect), 0);
    cyc(1, 1, 4'b0100, 0, 0);
    idle(2);
    cyc(1, 0, 4'b0, 1, 0);
    idle(2);
    cyc(1, 0, 4'b0, 1, 0);
    chk("spur_ack_isr", 64'(in_isr), 1);
    chk("spur_ack_redir", 64'(redirect), 0);
    cyc(1, 0, 4'b0, 0, 1);
    idle(3);

`ifdef INTDISP_MASK_EN
    mask_we = 1'b1; mask_wdata = 4'b1110;
    idle(1);
    mask_we = 1'b0;
    cyc(1, 1, 4'b0001, 0, 0);
    idle(4);
    chk("masked_idle", 64'(flush_req), 0);
    mask_we = 1'b1; mask_wdata = 4'b1111;
    idle(1);
    mask_we = 1'b0;
    idle(1);
    chk("unmask_flush", 64'(flush_req), 1);
    cyc(1, 0, 4'b0, 1, 0);
    chk("unmask_vector", 64'(redirect_pc), 64'h100);
    idle(2);
    cyc(1, 0, 4'b0, 0, 1);
    idle(3);
`endif

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      pc = $urandom;
`ifdef INTDISP_MASK_EN
      mask_we    = ($urandom_range(0, 99) < 3);
      mask_wdata = 4'($urandom);
`endif
      cyc(($urandom_range(0, 199) != 0),
          ($urandom_range(0, 99) < 15),
          4'($urandom),
          ($urandom_range(0, 99) < 30),
          ($urandom_range(0, 99) < 15));
    end
`ifdef INTDISP_MASK_EN
    mask_we = 1'b0;
`endif
    idle(4);
    @(negedge clk);
    chk("sb_drained", 64'(sbq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/interrupt_dispatch.md
Name: interrupt_dispatch

Overview:
Downstream consumer of the CPU's single-cycle interrupt pulse (inti) and the raw interrupt lines. Latches pending sources and selects the highest-priority one. Requests a pipeline flush, saves the interrupted PC (EPC) and redirects fetch to a per-source vector. Returns to EPC on mret and blocks nested entry while the handler runs.

Parameters:
XLEN, 32, PC/data width
NSRC, 4, number of interrupt sources (index 0 = highest priority)
VEC_BASE, 32'h0000_0100, vector table base address
VEC_STRIDE, 16, byte distance between vectors (power of two)

Ports:
CLK_I  in  1  clock
RST_N_I  in  1  reset; synchronous, active-low
inti  in  1  one-cycle "interrupt occurred" pulse from interrupt controller
irq_i  in  NSRC  raw interrupt lines (interrupt0..3), sampled on inti
pc_i  in  XLEN  PC of oldest un-retired instruction (the resume point)
flush_ack_i  in  1  pipeline drained and frozen
mret_i  in  1  one-cycle pulse: handler executed mret
flush_req_o  out  1  request pipeline flush/freeze
redirect_o  out  1  one-cycle fetch redirect strobe
redirect_pc_o  out  XLEN  target PC, valid with redirect_o
epc_o  out  XLEN  saved resume PC
cause_o  out  $clog2(NSRC)  index of the source being serviced
in_isr_o  out  1  handler active

Behaviour:
- Reset (RST_N_I low at posedge): state IDLE, pending=0, epc_o=0, cause_o=0; all 1-bit outputs 0; redirect_pc_o=0. Takes priority over every other event.
- Pending: on inti, pending |= irq_i. The dispatched bit clears on entry to REDIRECT. inti with irq_i==0 sets nothing.
- Selection: lowest set index of pending, combinational. Vector = VEC_BASE + idx*VEC_STRIDE, computed in XLEN bits with wrap modulo 2^XLEN.
- FSM states: IDLE, FLUSH, REDIRECT, ISR, RETURN.
  - IDLE: pending!=0 -> FLUSH next cycle.
  - FLUSH: flush_req_o=1. On flush_ack_i=1: capture epc_o<=pc_i and cause_o<=idx, then go to REDIRECT. Select idx from pending as it stands that cycle, so a higher-priority source arriving before the ack wins. Wait indefinitely otherwise.
  - REDIRECT: redirect_o=1 for exactly one cycle, redirect_pc_o=vector(cause_o), flush_req_o=0, pending[cause_o] cleared -> ISR.
  - ISR: in_isr_o=1. New inti pulses only update pending; no nesting. mret_i -> RETURN.
  - RETURN: redirect_o=1 for one cycle, redirect_pc_o=epc_o, in_isr_o=0. Next state is FLUSH if pending!=0 (back-to-back service; EPC re-captured from pc_i at the next ack), else IDLE.
- Latency: inti at cycle N -> flush_req_o at N+2 at earliest. flush_ack_i at cycle M -> redirect_o at M+1.
- Simultaneous events: inti in the same cycle as a pending clear gives set-wins for any bit not being cleared. When re-asserted for the bit being cleared, set-wins and the bit stays pending. mret_i outside ISR is ignored. flush_ack_i outside FLUSH is ignored.
- redirect_pc_o holds its last value when redirect_o=0.

Optional Feature:
Macro INTDISP_MASK_EN. When defined, add ports mask_we_i (1) and mask_wdata_i (NSRC), plus an NSRC-bit mask register that resets to all-ones (enabled) and is written when mask_we_i=1. Selection and the IDLE->FLUSH test use pending & mask; masked bits stay pending and dispatch once unmasked. When not defined, there are no mask ports and all sources are always enabled.

Decomposition:
- Package intdisp_pkg: the state enum (IDLE, FLUSH, REDIRECT, ISR, RETURN), default VEC_BASE/VEC_STRIDE constants, and a function computing the vector from an index.
- One sub-module: prio_enc (parameterised NSRC lowest-index-first priority encoder producing idx and a valid flag).

Test Plan:
- Reset mid-FLUSH: RST_N_I=0 one cycle -> next cycle state IDLE, flush_req_o=0, pending=0, epc_o=0.
- Single source: irq_i=4'b0100 with inti, pc_i=32'h0000_2000, ack 3 cycles later -> redirect_o one cycle with redirect_pc_o=32'h0000_0120, cause_o=2, epc_o=32'h2000, in_isr_o=1.
- Priority change during FLUSH: pending 4'b1000, then inti with 4'b0001 before ack -> cause_o=0, vector 32'h100; after mret (pc redirect 32'h2000) source 3 is serviced next, vector 32'h130.
- Nesting blocked: inti with 4'b0010 during ISR -> no flush_req_o until mret. RETURN redirects to epc_o, then FLUSH follows immediately.
- Spurious strobes: mret_i in IDLE and flush_ack_i in ISR -> no state change, no redirect_o.
- (INTDISP_MASK_EN) Write mask=4'b1110, then inti with 4'b0001 -> stays IDLE. Write mask=4'b1111 -> FLUSH follows, and service of source 0 proceeds with vector 32'h100.
